// File: rtl/mem_resp_pkg.sv
// Shared types and lane helpers for the load/store memory responder.
// Lanes are little-endian: byte k of a word sits at bits [8k+7:8k].
package mem_resp_pkg;

  typedef enum logic [2:0] {IDLE, RD, RMW, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Insert right-aligned store data into the addressed lane(s) of a word.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Pull the addressed lane(s) down to the low bits and extend.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word-wide synchronous RAM with registered read data (read-old-data on write).
module mem_word_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one load/store request at a time over valid/ready, sub-word stores
// done as read-modify-write against a word-wide synchronous array.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t        state_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [1:0]    off_q;
  logic [IW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          req_err;
  logic          ram_we;
  logic [IW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr[AW-1:2] >= (AW-2)'(DEPTH_WORDS)) req_err = 1'b1;
  end

  // The read is launched off the live request address on the accept edge so that the word
  // is already on ram_rdata while in RD; afterwards the registered address holds it there.
  always_comb begin
    ram_we    = !reset && ((state_q == WR) || (state_q == RMW));
    ram_addr  = (state_q == IDLE) ? req_addr[IW+1:2] : addr_q;
    ram_wdata = (state_q == WR) ? wdata_q : lane_merge(ram_rdata, wdata_q, size_q, off_q);
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            off_q     <= req_addr[1:0];
            addr_q    <= req_addr[IW+1:2];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (req_write && (req_size == SZ_WORD)) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          if (write_q) begin
            state_q <= RMW;
          end else begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= lane_extract(ram_rdata, size_q, off_q, signed_q);
          end
        end
        RMW, WR: begin
          state_q    <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        RESP: begin
          if (resp_ready) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store traffic. Accepts word, halfword and byte read/write requests over a valid/ready handshake.
- Services each request against an internal word-wide synchronous array. Sub-word stores are done as read-modify-write; sub-word loads are returned extracted and extended.
- Returns one response per request, with an error flag for misaligned or out-of-range addresses.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the internal array.
- AW, 32: request address width in bits; the address is a byte address.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range, or had an illegal size.

Behaviour:
- Reset:
  - state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - Array contents are not reset.
- Accept: a request is accepted on a cycle with req_valid & req_ready. All request fields are registered on that edge. req_ready=1 only in IDLE.
- Error check, done in IDLE at accept time:
  - size 3 is an error.
  - half with addr[0]!=0 is an error.
  - word with addr[1:0]!=0 is an error.
  - addr[AW-1:2] >= DEPTH_WORDS is an error.
  - On error: no array access; go to RESP with resp_err=1 and resp_rdata=0.
- Lane ordering is little-endian:
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane addr[1] occupies [31:16] when 1, [15:0] when 0.
- States:
  - IDLE: wait for accept. Error goes to RESP. Word store writes the array on the accept edge +1 (state WR) then goes to RESP. Any load or sub-word store goes to RD.
  - RD: array read issued; data is available the next cycle. Load goes to RESP. Sub-word store goes to RMW.
  - RMW: merge req_wdata into the addressed lane(s) of the read word and write the merged word back. Then go to RESP.
  - WR: word write. Then go to RESP.
  - RESP: resp_valid=1. Stay until resp_ready=1, then go to IDLE. resp_valid drops the following cycle.
- Latency from the accept edge to the first resp_valid=1 cycle:
  - error: 1 cycle.
  - word store: 2 cycles.
  - load: 2 cycles.
  - sub-word store: 3 cycles.
- Back-to-back throughput: one request per (latency + 1) cycles minimum, because IDLE is re-entered before the next accept.
- Load extraction:
  - The selected byte or half is placed in the low bits.
  - The upper bits are filled with its MSB if req_signed, else 0.
  - Word loads ignore req_signed.
- resp_rdata and resp_err are stable for as long as resp_valid=1 and resp_ready=0.
- Reset mid-operation:
  - The transaction is dropped and the state returns to IDLE.
  - If reset is high on the RMW or WR edge, the array write is suppressed.
  - No response is produced for the dropped request.
- Simultaneous events: a request presented while in RESP is not accepted (req_ready=0), even if resp_ready=1 in that cycle.

Decomposition:
- Package mem_resp_pkg holds:
  - typedef state_t {IDLE, RD, RMW, WR, RESP}.
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - functions lane_merge(word, wdata, size, off) and lane_extract(word, size, off, sgn).
- One sub-module, mem_word_array: parameterised DEPTH_WORDS×32 synchronous RAM.
  - Ports: clock, we, addr, wdata, rdata.
  - Read data is registered, with 1-cycle latency.

Test Plan:
- Word store then load:
  - Store 0xDEADBEEF to 0x10, then load word from 0x10.
  - Required: store response err=0 two cycles after accept; load returns 0xDEADBEEF two cycles after accept.
- Byte merge:
  - Store word 0x11223344 to 0x4, store byte 0xAA to 0x5, then load word from 0x4.
  - Required: 0x1122AA44; the byte store takes 3 cycles to respond.
- Sign handling:
  - Store byte 0x80 to 0x8.
  - Signed byte load from 0x8 returns 0xFFFFFF80; unsigned returns 0x00000080.
  - Half store 0x8001 to 0xA; signed half load from 0xA returns 0xFFFF8001.
- Errors:
  - Half load from 0x3, word store to 0x2, and word load from DEPTH_WORDS*4 each give resp_err=1 and rdata=0 one cycle after accept.
  - A following load of the word at 0x0 shows it unchanged.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after a load response appears.
  - Required: resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0 until resp_ready=1.
- Reset mid-RMW:
  - Assert reset during RMW of a byte store of 0x55 to 0x4 over contents 0x11223344.
  - Required: no response; outputs return to reset values; a later word load from 0x4 returns 0x11223344.
